e_mdu: RTL

- Multi-cycle multiply/divide unit in the E stage, alongside the combinational ALU.
- Executes mult/multu/div/divu and madd-family ops into architectural HI/LO registers.
- Serves mfhi/mflo reads and mthi/mtlo writes.
- Exposes a busy handshake that the hazard unit uses to stall D-stage MDU instructions.

---
 rtl/e_mdu_pkg.sv | 39 +++
 rtl/e_mdu_calc.sv | 117 +++++++++++
 rtl/e_mdu.sv | 137 +++++++++++++
 3 files changed

// File: rtl/e_mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: MDU op codes,
// default latencies, FSM state type and the calculator result bundle.
// The madd family codes are only accepted when MDU_MADD_EN is defined.
package e_mdu_pkg;

    // MDU operation codes carried on i_mdOp
    localparam logic [3:0] MD_none  = 4'd0;
    localparam logic [3:0] MD_mult  = 4'd1;
    localparam logic [3:0] MD_multu = 4'd2;
    localparam logic [3:0] MD_div   = 4'd3;
    localparam logic [3:0] MD_divu  = 4'd4;
    localparam logic [3:0] MD_mthi  = 4'd5;
    localparam logic [3:0] MD_mtlo  = 4'd6;
    localparam logic [3:0] MD_mfhi  = 4'd7;
    localparam logic [3:0] MD_mflo  = 4'd8;
    localparam logic [3:0] MD_madd  = 4'd9;
    localparam logic [3:0] MD_maddu = 4'd10;
    localparam logic [3:0] MD_msub  = 4'd11;
    localparam logic [3:0] MD_msubu = 4'd12;

    // Default busy latencies (legal range 1..15, counter is 4 bits)
    localparam int MDU_MUL_CYCLES = 5;
    localparam int MDU_DIV_CYCLES = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // What the calculator hands to the sequencer for a launched op
    typedef struct packed {
        logic        valid;   // op is a legal i_start operation
        logic        is_div;  // use the divide latency
        logic        acc;     // accumulate into HI/LO at completion
        logic        sub;     // accumulate by subtraction
        logic [63:0] res;     // {HI,LO} result or product to accumulate
    } mdu_calc_t;

endpackage

// File: rtl/e_mdu_calc.sv
// Combinational arithmetic core of the MDU: signed/unsigned 32x32 products
// and quotient/remainder, including the divide-by-zero and signed-overflow
// conventions. MDU_MADD_EN enables the madd/maddu/msub/msubu codes; without
// it they decode as unknown ops.
module e_mdu_calc
    import e_mdu_pkg::*;
(
    input  logic [3:0]  i_mdOp,
    input  logic [31:0] i_srcA,
    input  logic [31:0] i_srcB,
    output mdu_calc_t   o_calc
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic        [31:0] a_abs;
    logic        [31:0] b_abs;
    logic        [31:0] b_safe;
    logic        [31:0] uq_mag;
    logic        [31:0] ur_mag;
    logic        [31:0] sq;
    logic        [31:0] sr;
    logic        [31:0] uq;
    logic        [31:0] ur;
    logic               b_zero;
    logic               s_ovf;

    // Products, magnitudes and quotients shared by every op
    always_comb begin
        a_sx   = {{32{i_srcA[31]}}, i_srcA};
        b_sx   = {{32{i_srcB[31]}}, i_srcB};
        prod_s = a_sx * b_sx;
        prod_u = {32'd0, i_srcA} * {32'd0, i_srcB};

        b_zero = (i_srcB == 32'd0);
        s_ovf  = (i_srcA == 32'h8000_0000) && (i_srcB == 32'hFFFF_FFFF);

        // A zero divisor is replaced so the divider never sees it; the
        // result is overridden below anyway.
        b_safe = b_zero ? 32'd1 : i_srcB;
        a_abs  = i_srcA[31] ? (32'd0 - i_srcA) : i_srcA;
        b_abs  = i_srcB[31] ? (32'd0 - b_safe) : b_safe;

        uq_mag = a_abs / b_abs;
        ur_mag = a_abs % b_abs;
        // Truncate toward zero: quotient sign is the XOR of operand signs,
        // remainder follows the dividend.
        sq     = (i_srcA[31] ^ i_srcB[31]) ? (32'd0 - uq_mag) : uq_mag;
        sr     = i_srcA[31] ? (32'd0 - ur_mag) : ur_mag;

        uq     = i_srcA / b_safe;
        ur     = i_srcA % b_safe;
    end

    // Op decode and result selection
    always_comb begin
        o_calc        = '0;
        case (i_mdOp)
            MD_mult: begin
                o_calc.valid = 1'b1;
                o_calc.res   = prod_s;
            end
            MD_multu: begin
                o_calc.valid = 1'b1;
                o_calc.res   = prod_u;
            end
            MD_div: begin
                o_calc.valid  = 1'b1;
                o_calc.is_div = 1'b1;
                if (b_zero) begin
                    o_calc.res = {i_srcA, 32'hFFFF_FFFF};
                end else if (s_ovf) begin
                    o_calc.res = {32'd0, 32'h8000_0000};
                end else begin
                    o_calc.res = {sr, sq};
                end
            end
            MD_divu: begin
                o_calc.valid  = 1'b1;
                o_calc.is_div = 1'b1;
                if (b_zero) begin
                    o_calc.res = {i_srcA, 32'hFFFF_FFFF};
                end else begin
                    o_calc.res = {ur, uq};
                end
            end
`ifdef MDU_MADD_EN
            MD_madd: begin
                o_calc.valid = 1'b1;
                o_calc.acc   = 1'b1;
                o_calc.res   = prod_s;
            end
            MD_maddu: begin
                o_calc.valid = 1'b1;
                o_calc.acc   = 1'b1;
                o_calc.res   = prod_u;
            end
            MD_msub: begin
                o_calc.valid = 1'b1;
                o_calc.acc   = 1'b1;
                o_calc.sub   = 1'b1;
                o_calc.res   = prod_s;
            end
            MD_msubu: begin
                o_calc.valid = 1'b1;
                o_calc.acc   = 1'b1;
                o_calc.sub   = 1'b1;
                o_calc.res   = prod_u;
            end
`endif
            default: o_calc = '0;
        endcase
    end

endmodule

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: launches mult/multu/div/divu (and, with
// MDU_MADD_EN defined, madd/maddu/msub/msubu) on i_start, holds the result
// in pending registers for a fixed latency, then commits it to HI/LO.
// Also serves mthi/mtlo writes and mfhi/mflo reads.
module e_mdu
    import e_mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_srcA,
    input  logic [31:0] i_srcB,
    input  logic [3:0]  i_mdOp,
    input  logic        i_start,
    output logic        o_busy,
    output logic [31:0] o_HI,
    output logic [31:0] o_LO,
    output logic [31:0] o_result
);

    localparam logic [3:0] MUL_N = 4'(MUL_CYCLES);
    localparam logic [3:0] DIV_N = 4'(DIV_CYCLES);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic        busy_q,  busy_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;
    logic [63:0] pend_q,  pend_d;
    logic        acc_q,   acc_d;
    logic        sub_q,   sub_d;

    mdu_calc_t   calc;
    logic [63:0] hilo;
    logic [63:0] commit;

    e_mdu_calc u_calc (
        .i_mdOp (i_mdOp),
        .i_srcA (i_srcA),
        .i_srcB (i_srcB),
        .o_calc (calc)
    );

    // Value written to {HI,LO} on the completion edge; accumulating ops
    // combine with HI/LO as they stand at that edge.
    always_comb begin
        hilo = {hi_q, lo_q};
        if (acc_q) begin
            commit = sub_q ? (hilo - pend_q) : (hilo + pend_q);
        end else begin
            commit = pend_q;
        end
    end

    // Sequencer: launch, count down, commit; moves to HI/LO only when idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        acc_d   = acc_q;
        sub_d   = sub_q;
        case (state_q)
            ST_IDLE: begin
                if (i_start && calc.valid) begin
                    pend_d  = calc.res;
                    acc_d   = calc.acc;
                    sub_d   = calc.sub;
                    cnt_d   = calc.is_div ? DIV_N : MUL_N;
                    state_d = ST_BUSY;
                    busy_d  = 1'b1;
                end else if (i_mdOp == MD_mthi) begin
                    hi_d = i_srcA;
                end else if (i_mdOp == MD_mtlo) begin
                    lo_d = i_srcA;
                end
            end
            ST_BUSY: begin
                // Counter holds the number of busy cycles still to run,
                // so a value of 1 marks the completion edge.
                if (cnt_q == 4'd1) begin
                    {hi_d, lo_d} = commit;
                    cnt_d        = 4'd0;
                    state_d      = ST_IDLE;
                    busy_d       = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State registers; reset clears everything, aborting any op in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_q  <= 64'd0;
            acc_q   <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
            acc_q   <= acc_d;
            sub_q   <= sub_d;
        end
    end

    // mfhi/mflo read path
    always_comb begin
        case (i_mdOp)
            MD_mfhi: o_result = hi_q;
            MD_mflo: o_result = lo_q;
            default: o_result = 32'd0;
        endcase
    end

    assign o_busy = busy_q;
    assign o_HI   = hi_q;
    assign o_LO   = lo_q;

endmodule
